tick_gen: RTL and testbench
===========================

Name: tick_gen

Overview:
- Programmable clock-enable generator running on the fast clock domain.
- Emits a single-cycle `tick` every DIV fastclk cycles, plus a derived square wave `slowclk` that toggles on each tick.
- Supplies the clk/fastclk relationship that the existing rate-measurement logic checks, so benches and the top level get a known, reprogrammable clock ratio.
- The divide ratio is reloaded at runtime through a valid/ready handshake and takes effect only on a period boundary.

Parameters:
- CNT_W, 32: width of the divider, the period counter and `div_value`.
- DIV_DEFAULT, 4: active divide ratio after reset. Must be ≥1.
- TCNT_W, 32: width of the `tick_count` output.

Ports:
- fastclk  in  1  sole clock, rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- enable  in  1  run request. 1 = generate ticks, 0 = idle.
- div_valid  in  1  new divide ratio offered.
- div_value  in  CNT_W  offered divide ratio.
- div_ready  out  1  ratio can be accepted this cycle.
- tick  out  1  one-cycle pulse at each period end. Registered.
- slowclk  out  1  toggles on every tick, so its period is 2×DIV. Registered.
- tick_count  out  TCNT_W  number of ticks since reset. Wraps.
- err_zero  out  1  sticky: a zero ratio was offered.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, reset_l=0):
  - Outputs: tick=0, slowclk=0, tick_count=0, err_zero=0, busy=0, div_ready=1.
  - Internal: state=IDLE, period counter=0, active div=DIV_DEFAULT.
  - Reset mid-period or mid-reload aborts everything immediately, including any pending ratio.
- States: IDLE, RUN, PEND (running with a reload waiting).
- IDLE:
  - Counter held at 0, tick=0, slowclk holds its last value.
  - enable=1 sampled → RUN next cycle.
  - An accepted ratio is applied to the active div at the same edge.
  - An accept and an enable rise on the same edge → the new ratio governs the first period.
- RUN:
  - Counter increments every cycle.
  - When counter==div-1: counter→0, tick=1 on the next cycle, slowclk toggles, tick_count += 1.
  - First tick appears exactly `div` cycles after the cycle enable was sampled high.
  - div=1 → tick high on every cycle.
- Handshake:
  - Transfer occurs when div_valid & div_ready at a rising edge.
  - In RUN, an accepted non-zero value is stored as pending → PEND, and div_ready=0 from the next cycle.
  - div_value=0 always completes the handshake but is discarded. err_zero=1 (sticky until reset) and the state is unchanged.
- PEND:
  - Counts exactly as in RUN with the old div.
  - At the period-end edge, active div ← pending and counter→0 → RUN. The period just ending still uses the old div.
  - div_ready returns to 1 the cycle after the switch.
- Enable drop:
  - enable=0 sampled in RUN or PEND → IDLE next cycle, counter cleared, no tick.
  - A pending value is applied to the active div at that edge.
  - enable=0 on the exact period-end edge → that tick is still emitted.
- Width and wrap:
  - Counter and div are CNT_W unsigned.
  - tick_count wraps from 2^TCNT_W-1 to 0 without flagging.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- TICK_GEN_ASSERT_EN.
- Defined: concurrent assertions clocked on fastclk, disabled while reset_l=0.
  - tick never high on two consecutive cycles unless active div==1.
  - div_ready low only in PEND.
  - Active div never 0.
  - Cover points: a reload completing, err_zero rising, tick_count wrap.
- Undefined: none of the above is compiled in; RTL function is identical.

Decomposition:
- Package tick_gen_pkg holds:
  - the state enum (IDLE, RUN, PEND);
  - CNT_W_DEF = 32 and DIV_DEFAULT_DEF = 4 constants.
- One sub-module, tick_gen_period:
  - loadable CNT_W period counter;
  - inputs: clear, run, div;
  - output: single-cycle `wrap` at counter==div-1.
- The top module owns the FSM, handshake, slowclk, tick_count and err_zero.

Test Plan:
- Reset, enable=1 with default div 4 → first tick 4 cycles after enable sampled, then every 4 cycles. slowclk period 8. tick_count=3 after the 3rd tick.
- While RUN with div 4, offer div_value=10 mid-period → div_ready=0 next cycle. Current period still ends after 4, next periods are 10. div_ready=1 after the switch.
- Offer div_value=0 in RUN → handshake completes, err_zero=1 stays set, tick spacing unchanged at 4. Only reset clears err_zero.
- div_value=1 accepted in IDLE with simultaneous enable rise → tick high every cycle from the first tick. slowclk toggles every cycle.
- Drop enable during PEND (pending 7) → IDLE next cycle with no tick. Re-enable gives first tick 7 cycles later.
- Assert reset_l=0 mid-period in PEND → all outputs reset values immediately. After release, enable gives DIV_DEFAULT spacing and the pending value is lost.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
// Shared definitions for the tick_gen clock-enable generator.
//   state_t         : control FSM states (IDLE, RUN, PEND)
//   CNT_W_DEF       : default divider / counter width
//   DIV_DEFAULT_DEF : default divide ratio after reset
package tick_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // stopped, counter held at 0
    RUN  = 2'd1,  // generating ticks with the active ratio
    PEND = 2'd2   // generating ticks, a new ratio waits for the period end
  } state_t;

  localparam int CNT_W_DEF       = 32;
  localparam int DIV_DEFAULT_DEF = 4;

endpackage

// File: rtl/tick_gen_period.sv
// tick_gen_period
// Period counter for tick_gen. Counts 0 .. i_div-1 while running and
// flags the last count of each period.
// Ports:
//   fastclk  in   clock, rising edge
//   reset_l  in   asynchronous active-low reset
//   i_clear  in   force the counter to 0 (wins over i_run)
//   i_run    in   count this cycle
//   i_div    in   CNT_W  active divide ratio (never 0)
//   o_wrap   out  high while running and counter == i_div-1
module tick_gen_period #(
  parameter int CNT_W = 32
) (
  input  logic             fastclk,
  input  logic             reset_l,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == (i_div - ONE));
  // Wrap is qualified by i_run only, not by i_clear, so a period that ends
  // on the same edge as a stop request still produces its tick.
  assign o_wrap   = i_run & w_at_end;

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_at_end ? '0 : (r_cnt + ONE);
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen
// Programmable clock-enable generator: a one-cycle tick every DIV fastclk
// cycles, a slowclk square wave toggling on every tick, and a wrapping
// tick counter. The ratio is reloaded through a valid/ready handshake and
// only takes effect on a period boundary (or when the generator stops).
// Optional build macro: TICK_GEN_ASSERT_EN adds assertions and cover points.
// Ports:
//   fastclk     in   sole clock, rising edge
//   reset_l     in   asynchronous active-low reset
//   enable      in   1 = generate ticks, 0 = idle
//   div_valid   in   new ratio offered
//   div_value   in   CNT_W offered ratio (0 is rejected, sets err_zero)
//   div_ready   out  ratio can be accepted this cycle (low only in PEND)
//   tick        out  one-cycle pulse at each period end
//   slowclk     out  toggles on every tick
//   tick_count  out  TCNT_W ticks since reset, wraps
//   err_zero    out  sticky: a zero ratio was offered
//   busy        out  state != IDLE
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
  parameter int TCNT_W      = 32
) (
  input  logic              fastclk,
  input  logic              reset_l,
  input  logic              enable,
  input  logic              div_valid,
  input  logic [CNT_W-1:0]  div_value,
  output logic              div_ready,
  output logic              tick,
  output logic              slowclk,
  output logic [TCNT_W-1:0] tick_count,
  output logic              err_zero,
  output logic              busy
);

  localparam logic [CNT_W-1:0]  DIV_INIT = CNT_W'(DIV_DEFAULT);
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_div;
  logic [CNT_W-1:0]    w_div_next;
  logic [CNT_W-1:0]    r_pend;
  logic [CNT_W-1:0]    w_pend_next;
  logic                r_tick;
  logic                r_slowclk;
  logic [TCNT_W-1:0]   r_tick_count;
  logic                r_err_zero;

  logic w_run;
  logic w_clear;
  logic w_wrap;
  logic w_accept;
  logic w_zero;
  logic w_load;

  assign w_run    = (r_state != IDLE);
  // Stopping clears the counter at the same edge the state returns to IDLE.
  assign w_clear  = (r_state == IDLE) | ~enable;

  assign div_ready = (r_state != PEND);
  assign w_accept  = div_valid & div_ready;
  assign w_zero    = (div_value == '0);
  assign w_load    = w_accept & ~w_zero;

  tick_gen_period #(
    .CNT_W (CNT_W)
  ) u_period (
    .fastclk (fastclk),
    .reset_l (reset_l),
    .i_clear (w_clear),
    .i_run   (w_run),
    .i_div   (r_div),
    .o_wrap  (w_wrap)
  );

  // Next-state and ratio bookkeeping.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_pend_next  = r_pend;
    case (r_state)
      IDLE: begin
        // A ratio accepted together with the enable rise governs the
        // very first period.
        if (w_load) w_div_next = div_value;
        if (enable) w_state_next = RUN;
      end
      RUN: begin
        if (!enable) begin
          // Stopping: nothing to wait for, apply the new ratio directly.
          w_state_next = IDLE;
          if (w_load) w_div_next = div_value;
        end else if (w_load) begin
          w_pend_next  = div_value;
          w_state_next = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          w_state_next = IDLE;
          w_div_next   = r_pend;
        end else if (w_wrap) begin
          w_state_next = RUN;
          w_div_next   = r_pend;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      r_div        <= DIV_INIT;
      r_pend       <= '0;
      r_tick       <= 1'b0;
      r_slowclk    <= 1'b0;
      r_tick_count <= '0;
      r_err_zero   <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_pend <= w_pend_next;
      r_tick <= w_wrap;
      if (w_wrap) begin
        r_slowclk    <= ~r_slowclk;
        r_tick_count <= r_tick_count + TCNT_ONE;
      end
      if (w_accept && w_zero) r_err_zero <= 1'b1;
    end
  end

  assign tick       = r_tick;
  assign slowclk    = r_slowclk;
  assign tick_count = r_tick_count;
  assign err_zero   = r_err_zero;
  assign busy       = (r_state != IDLE);

`ifdef TICK_GEN_ASSERT_EN
  // Back-to-back ticks are legal only when the period that produced the
  // second one had a ratio of 1.
  a_tick_spacing: assert property (@(posedge fastclk) disable iff (!reset_l)
    (r_tick && $past(r_tick)) |-> ($past(r_div) == CNT_W'(1)));
  a_ready_pend: assert property (@(posedge fastclk) disable iff (!reset_l)
    !div_ready |-> (r_state == PEND));
  a_div_nonzero: assert property (@(posedge fastclk) disable iff (!reset_l)
    r_div != '0);
  c_reload: cover property (@(posedge fastclk) disable iff (!reset_l)
    (r_state == PEND) && (w_state_next == RUN));
  c_err_rise: cover property (@(posedge fastclk) disable iff (!reset_l)
    $rose(r_err_zero));
  c_count_wrap: cover property (@(posedge fastclk) disable iff (!reset_l)
    w_wrap && (r_tick_count == '1));
`else
`endif

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen
// Directed bench for tick_gen with default parameters (CNT_W=32, DIV=4).
module tb_tick_gen;

  logic        fastclk;
  logic        reset_l;
  logic        enable;
  logic        div_valid;
  logic [31:0] div_value;
  logic        div_ready;
  logic        tick;
  logic        slowclk;
  logic [31:0] tick_count;
  logic        err_zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for the slow outputs, advanced by expected ticks only.
  logic        exp_slow;
  logic [31:0] exp_cnt;

  tick_gen dut (
    .fastclk    (fastclk),
    .reset_l    (reset_l),
    .enable     (enable),
    .div_valid  (div_valid),
    .div_value  (div_value),
    .div_ready  (div_ready),
    .tick       (tick),
    .slowclk    (slowclk),
    .tick_count (tick_count),
    .err_zero   (err_zero),
    .busy       (busy)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end else begin
      $display("ok   %s = %0h at %0t", tag, obs, $time);
    end
  endtask

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  // Reset is checked before any clock edge to show it acts asynchronously.
  task automatic apply_reset();
    reset_l   = 1'b0;
    enable    = 1'b0;
    div_valid = 1'b0;
    div_value = '0;
    #1;
    check("rst_tick", tick, 1'b0);
    check("rst_slowclk", slowclk, 1'b0);
    check("rst_tick_count", tick_count, 32'd0);
    check("rst_err_zero", err_zero, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_div_ready", div_ready, 1'b1);
    exp_slow = 1'b0;
    exp_cnt  = '0;
    step();
    step();
    reset_l = 1'b1;
    step();
  endtask

  // Step n cycles; ticks are expected at steps first, first+period, ...
  task automatic run_expect(input int n, input int first, input int period);
    logic exp_t;
    for (int i = 1; i <= n; i++) begin
      step();
      exp_t = (i >= first) && (((i - first) % period) == 0);
      if (exp_t) begin
        exp_slow = ~exp_slow;
        exp_cnt  = exp_cnt + 32'd1;
      end
      check("tick", tick, exp_t);
      check("slowclk", slowclk, exp_slow);
      check("tick_count", tick_count, exp_cnt);
    end
  endtask

  initial begin
    exp_slow  = 1'b0;
    exp_cnt   = '0;
    reset_l   = 1'b1;
    enable    = 1'b0;
    div_valid = 1'b0;
    div_value = '0;
    #2;

    // Default ratio 4: first tick 4 cycles after enable sampled.
    apply_reset();
    enable = 1'b1;
    run_expect(16, 5, 4);
    check("t1_busy", busy, 1'b1);
    check("t1_count3", tick_count, 32'd3);

    // Reload 10 mid-period: current period ends on 4, then 10s.
    apply_reset();
    enable = 1'b1;
    step();
    step();
    div_valid = 1'b1;
    div_value = 32'd10;
    step();
    div_valid = 1'b0;
    check("t2_ready_low", div_ready, 1'b0);
    check("t2_busy", busy, 1'b1);
    step();
    check("t2_tick_pre", tick, 1'b0);
    check("t2_ready_still_low", div_ready, 1'b0);
    run_expect(24, 1, 10);
    check("t2_ready_back", div_ready, 1'b1);

    // Zero ratio: accepted, discarded, err_zero sticky.
    apply_reset();
    enable = 1'b1;
    step();
    step();
    div_valid = 1'b1;
    div_value = 32'd0;
    check("t3_ready", div_ready, 1'b1);
    step();
    div_valid = 1'b0;
    check("t3_err_set", err_zero, 1'b1);
    check("t3_not_pend", div_ready, 1'b1);
    run_expect(12, 2, 4);
    check("t3_err_sticky", err_zero, 1'b1);

    // Ratio 1 accepted in IDLE together with enable rise.
    apply_reset();
    div_valid = 1'b1;
    div_value = 32'd1;
    enable    = 1'b1;
    step();
    div_valid = 1'b0;
    check("t4_tick_first", tick, 1'b0);
    run_expect(6, 1, 1);

    // Enable drop during PEND (pending 7), then re-enable.
    apply_reset();
    enable = 1'b1;
    step();
    div_valid = 1'b1;
    div_value = 32'd7;
    step();
    div_valid = 1'b0;
    check("t5_pend", div_ready, 1'b0);
    enable = 1'b0;
    step();
    check("t5_idle_busy", busy, 1'b0);
    check("t5_idle_tick", tick, 1'b0);
    check("t5_idle_ready", div_ready, 1'b1);
    step();
    check("t5_idle_tick2", tick, 1'b0);
    enable = 1'b1;
    run_expect(15, 8, 7);

    // Enable drop exactly on the period-end edge still emits that tick.
    apply_reset();
    enable = 1'b1;
    run_expect(4, 5, 4);
    enable = 1'b0;
    step();
    check("t6_edge_tick", tick, 1'b1);
    check("t6_edge_busy", busy, 1'b0);
    check("t6_edge_count", tick_count, 32'd1);
    check("t6_edge_slow", slowclk, 1'b1);

    // Reset while PEND: pending ratio lost, default spacing returns.
    apply_reset();
    enable = 1'b1;
    step();
    div_valid = 1'b1;
    div_value = 32'd9;
    step();
    div_valid = 1'b0;
    step();
    check("t7_pend_busy", busy, 1'b1);
    apply_reset();
    enable = 1'b1;
    run_expect(13, 5, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
